dmem_bridge: RTL and testbench
==============================

# dmem_bridge

Multi-cycle data-memory bridge between the single-cycle ARM datapath and an external handshaked memory bus. It takes the load/store address and store data from the datapath, runs one bus transaction per memory instruction, and returns the load data. It drives a `Stall` signal that freezes PC and register-file writes until the access completes. It replaces the ideal zero-latency data memory without changing the datapath's ALU or register interface.

## Interface
- `ADDR_W`, 32, bus/ALU address width
- `DATA_W`, 32, data width
- `TIMEOUT_CYC`, 255, watchdog limit in cycles; used only when `DMEM_BRIDGE_TIMEOUT_EN` is defined
- `clk` in 1: the single clock
- `reset` in 1: asynchronous, active-low
- `MemAccess` in 1: current instruction is a load or store
- `MemWrite` in 1: 1 = store, 0 = load; valid while `MemAccess`
- `ALUResult` in ADDR_W: byte address from the ALU
- `WriteData` in DATA_W: store data from register file port 2
- `ReadData` out DATA_W: load result; reset 0
- `Stall` out 1: datapath must not commit this cycle; reset 0
- `BusErr` out 1: one-cycle pulse in DONE on error; reset 0
- `bus_req` out 1: request valid; reset 0
- `bus_we` out 1: request is a write; reset 0
- `bus_addr` out ADDR_W: word-aligned address; reset 0
- `bus_wdata` out DATA_W: write data; reset 0
- `bus_gnt` in 1: bus accepts the request this cycle
- `bus_rvalid` in 1: response valid (read data or write ack)
- `bus_rdata` in DATA_W: read data
- `bus_err` in 1: response carries an error; qualified by `bus_rvalid`

## Operation
- FSM states are IDLE, REQ, RESP and DONE.
- **IDLE:** when `MemAccess`=1, the block latches `ALUResult`, `WriteData` and `MemWrite` into internal registers.
  - If `ALUResult[1:0]`≠0 (misaligned), the next state is DONE with error flagged and no bus traffic.
  - Otherwise the next state is REQ.
- **REQ:**
  - `bus_req`=1. `bus_addr`, `bus_we` and `bus_wdata` come from the latched registers and stay stable until granted.
  - `bus_gnt`=1 moves the FSM to RESP. `bus_req` is low in RESP.
- **RESP:**
  - Waits for `bus_rvalid`. `bus_rvalid` is ignored in every other state.
  - On `bus_rvalid` for a load, `ReadData`←`bus_rdata`, or 0 if `bus_err`. The next state is DONE.
  - On `bus_rvalid` for a store, `ReadData` holds its value.
- **DONE:**
  - `Stall`=0, so the datapath commits at this edge.
  - `BusErr`=1 if a misalignment, `bus_err` or timeout was flagged.
  - The next state is IDLE unconditionally.
- **`Stall`:** combinational, equal to `MemAccess` & (state≠DONE). Non-memory instructions never stall.
- **`ReadData` hold:** `ReadData` keeps its value until the next load response, so it is stable through DONE.
- **Back-to-back memory instructions:** the IDLE visit after DONE starts the next access. There is no bypass.
- **`MemAccess` dropping:** if `MemAccess` falls outside IDLE (which only happens on a datapath bug), the FSM still completes the transaction.

## Timing
- Minimum memory instruction is 4 cycles: IDLE (stall), REQ with `bus_gnt`, RESP with `bus_rvalid`, DONE (commit).
- Every grant-wait cycle or response-wait cycle adds 1 cycle.
- Misaligned access takes 2 cycles: IDLE, then DONE with `BusErr`.
- All outputs except `Stall` are registered.
- `bus_gnt` and `bus_rvalid` are never combinationally looped into bus outputs.
- Reset asserted at any point returns the FSM to IDLE immediately and clears all outputs.
  - Any in-flight bus transaction is abandoned.
  - The bus slave must tolerate a `bus_req` drop.

## Configuration
- `DMEM_BRIDGE_TIMEOUT_EN` defined:
  - A counter clears on entry to REQ and increments in REQ and RESP.
  - When it reaches `TIMEOUT_CYC`, the FSM goes to DONE, `bus_req` drops, `BusErr` is flagged and `ReadData`←0 for loads.
  - Responses arriving later in IDLE are ignored.
- Not defined: no counter; the FSM waits indefinitely in REQ and RESP.

## Structure
- The package `dmem_pkg` holds:
  - the state enum `dmem_state_t` {IDLE, REQ, RESP, DONE};
  - `WORD_ALIGN_MASK` = 2'b11;
  - the default timeout constant.
- One sub-module, `dmem_watchdog`, is the timeout counter with `clear`, `enable` and `expired` signals. It is instantiated only under `DMEM_BRIDGE_TIMEOUT_EN`.

## Test plan
- Load 0x100, `bus_gnt` and `bus_rvalid` each in the first cycle, `bus_rdata`=0xDEADBEEF → `Stall` high 3 cycles, DONE with `ReadData`=0xDEADBEEF, `BusErr`=0.
- Store 0x204 data 0x12345678, `bus_gnt` delayed 3 cycles → `bus_addr`/`bus_wdata`/`bus_we`=1 stable for 4 REQ cycles, `Stall` high 6 cycles, `ReadData` unchanged.
- Load at 0x102 → no `bus_req`, DONE on 2nd cycle with `BusErr` pulse, `ReadData`=0.
- Load with `bus_rvalid`+`bus_err` → `ReadData`=0, `BusErr`=1 for exactly one cycle.
- Reset pulled low during RESP → `bus_req`/`Stall`/`BusErr` 0 immediately, FSM IDLE; a subsequent load completes normally.
- With `DMEM_BRIDGE_TIMEOUT_EN`, `TIMEOUT_CYC`=8, `bus_gnt` never asserted → DONE after 8 REQ cycles with `BusErr`; without the macro `Stall` stays high.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory bus bridge.
package dmem_pkg;

  // Bridge FSM: accept in IDLE, hold request in REQ, await response in RESP,
  // and let the datapath commit in DONE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } dmem_state_t;

  // Byte-offset bits that must be zero for a word access.
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  // Default watchdog limit in cycles spent in REQ and RESP.
  localparam int DEFAULT_TIMEOUT_CYC = 255;

endpackage : dmem_pkg

// File: rtl/dmem_watchdog.sv
// Transaction watchdog: counts cycles while enabled and flags expiry on the
// LIMIT-th counted cycle. Only instantiated when DMEM_BRIDGE_TIMEOUT_EN is set.
module dmem_watchdog
  import dmem_pkg::*;
#(
  parameter int LIMIT = DEFAULT_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Expiry fires during the cycle that completes LIMIT counted cycles.
  assign expired = enable && (cnt_q == CW'(LIMIT - 1));

  // Next count: clear wins, then count while enabled, saturating at expiry.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : dmem_watchdog

// File: rtl/dmem_bridge.sv
// Multi-cycle bridge from the single-cycle datapath to a handshaked memory
// bus. One bus transaction per memory instruction; Stall freezes the datapath
// until the access completes. Optional watchdog: DMEM_BRIDGE_TIMEOUT_EN.
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemAccess,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              Stall,
  output logic              BusErr,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_err
);

  dmem_state_t       state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic              bus_err_q, bus_err_d;
  logic              wd_clear;
  logic              timeout_hit;
  logic              misaligned;

  assign misaligned = |(ALUResult[1:0] & WORD_ALIGN_MASK);

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  dmem_watchdog #(
    .LIMIT (TIMEOUT_CYC)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  ((state_q == REQ) || (state_q == RESP)),
    .expired (timeout_hit)
  );
`else
  // TIMEOUT_CYC has no effect in this build; the always-false term keeps it referenced.
  assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

  // Combinational stall, forced low while reset is held.
  assign Stall     = reset && MemAccess && (state_q != DONE);
  assign ReadData  = read_data_q;
  assign BusErr    = bus_err_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

  // Next-state and registered-output logic for the access FSM.
  // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    read_data_d = read_data_q;
    bus_err_d   = 1'b0;
    wd_clear    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (MemAccess) begin
          bus_addr_d  = ALUResult & ~{{(ADDR_W-2){1'b0}}, WORD_ALIGN_MASK};
          bus_wdata_d = WriteData;
          bus_we_d    = MemWrite;
          if (misaligned) begin
            // Misaligned loads return 0, like every other failed load.
            state_d   = DONE;
            bus_err_d = 1'b1;
            if (!MemWrite) read_data_d = '0;
          end else begin
            state_d   = REQ;
            bus_req_d = 1'b1;
            wd_clear  = 1'b1;
          end
        end
      end
      REQ: begin
        if (bus_gnt) begin
          state_d   = RESP;
          bus_req_d = 1'b0;
        end else if (timeout_hit) begin
          state_d   = DONE;
          bus_req_d = 1'b0;
          bus_err_d = 1'b1;
          if (!bus_we_q) read_data_d = '0;
        end
      end
      RESP: begin
        if (bus_rvalid) begin
          state_d   = DONE;
          bus_err_d = bus_err;
          if (!bus_we_q) read_data_d = bus_err ? '0 : bus_rdata;
        end else if (timeout_hit) begin
          state_d   = DONE;
          bus_err_d = 1'b1;
          if (!bus_we_q) read_data_d = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight transaction.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      read_data_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      read_data_q <= read_data_d;
      bus_err_q   <= bus_err_d;
    end
  end

endmodule : dmem_bridge

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge. Acts as datapath and bus slave; keeps a
// transaction-level model of ReadData, BusErr and per-access stall length.
module tb_dmem_bridge;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  localparam int TB_TIMEOUT = 8;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        MemAccess, MemWrite;
  logic [31:0] ALUResult, WriteData;
  logic [31:0] ReadData;
  logic        Stall, BusErr;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_gnt, bus_rvalid, bus_err;
  logic [31:0] bus_rdata;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] rd_model = 32'h0;

  always #5 clk = ~clk;

  dmem_bridge #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .TIMEOUT_CYC (TB_TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .MemAccess  (MemAccess),
    .MemWrite   (MemWrite),
    .ALUResult  (ALUResult),
    .WriteData  (WriteData),
    .ReadData   (ReadData),
    .Stall      (Stall),
    .BusErr     (BusErr),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata),
    .bus_err    (bus_err)
  );

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    MemAccess = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    rd_model = 32'h0;
    @(negedge clk);
  endtask

  // One memory instruction, entered and left on a falling edge. gnt_dly /
  // rsp_dly are wait cycles before grant / response. keep leaves MemAccess
  // high so the next call runs back-to-back.
  task automatic run_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                            input int gnt_dly, input int rsp_dly, input logic [31:0] rdata,
                            input bit err, input bit keep, input string name);
    bit mis, to, done, seen_req, req_ok;
    int stall_cnt, req_cnt, resp_cnt, exp_stall;
    bit exp_err;
    mis = (addr[1:0] != 2'b00);
`ifdef DMEM_BRIDGE_TIMEOUT_EN
    to = !mis && (gnt_dly >= TB_TIMEOUT);
`else
    to = 1'b0;
`endif
    exp_stall = mis ? 1 : (to ? 1 + TB_TIMEOUT : gnt_dly + rsp_dly + 3);
    exp_err   = mis || to || err;
    if (!we) rd_model = (mis || to || err) ? 32'h0 : rdata;

    MemAccess = 1'b1; MemWrite = we; ALUResult = addr; WriteData = wdata;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0;
    done = 0; seen_req = 0; req_ok = 1; stall_cnt = 0; req_cnt = 0; resp_cnt = 0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      #1;
      if (Stall === 1'b0) begin
        done = 1;
      end else begin
        stall_cnt++;
        if (bus_req === 1'b1) begin
          seen_req = 1;
          req_cnt++;
          if (bus_addr !== {addr[31:2], 2'b00} || bus_we !== we || bus_wdata !== wdata) req_ok = 0;
          bus_gnt    = (req_cnt > gnt_dly);
          // A response outside RESP must be ignored.
          bus_rvalid = 1'($urandom_range(0, 1));
          bus_rdata  = $urandom;
          bus_err    = 1'($urandom_range(0, 1));
        end else if (seen_req) begin
          bus_gnt = 1'b0;
          resp_cnt++;
          bus_rvalid = (resp_cnt > rsp_dly);
          bus_rdata  = bus_rvalid ? rdata : $urandom;
          bus_err    = bus_rvalid ? err : 1'($urandom_range(0, 1));
        end
        @(negedge clk);
      end
    end

    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL %s: access never completed (Stall stuck), got stall=%0d cycles, want %0d", name, stall_cnt, exp_stall);
      pulse_reset();
      return;
    end
    n_cmp++;
    if (stall_cnt !== exp_stall) begin
      n_bad++;
      $display("FAIL %s stall_len: got %0d want %0d", name, stall_cnt, exp_stall);
    end
    n_cmp++;
    if (BusErr !== exp_err) begin
      n_bad++;
      $display("FAIL %s BusErr in DONE: got %b want %b", name, BusErr, exp_err);
    end
    n_cmp++;
    if (ReadData !== rd_model) begin
      n_bad++;
      $display("FAIL %s ReadData in DONE: got %h want %h", name, ReadData, rd_model);
    end
    n_cmp++;
    if (seen_req !== !mis || req_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL %s bus request: seen=%b stable=%b want seen=%b stable=1", name, seen_req, req_ok, !mis);
    end
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0;
    MemAccess = keep;
    @(negedge clk);
    n_cmp++;
    if (BusErr !== 1'b0 || ReadData !== rd_model) begin
      n_bad++;
      $display("FAIL %s after DONE: BusErr=%b ReadData=%h want 0/%h", name, BusErr, ReadData, rd_model);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    MemAccess = 1'b1; MemWrite = 1'b0; ALUResult = 32'h100; WriteData = 32'h0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0; bus_err = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (Stall !== 1'b0) begin n_bad++; $display("FAIL reset Stall: got %b want 0", Stall); end
    n_cmp++;
    if (bus_req !== 1'b0 || bus_we !== 1'b0) begin
      n_bad++; $display("FAIL reset bus_req/we: got %b/%b want 0/0", bus_req, bus_we);
    end
    n_cmp++;
    if (bus_addr !== 32'h0 || bus_wdata !== 32'h0) begin
      n_bad++; $display("FAIL reset bus_addr/wdata: got %h/%h want 0/0", bus_addr, bus_wdata);
    end
    n_cmp++;
    if (ReadData !== 32'h0 || BusErr !== 1'b0) begin
      n_bad++; $display("FAIL reset ReadData/BusErr: got %h/%b want 0/0", ReadData, BusErr);
    end
    MemAccess = 1'b0;
    reset = 1'b1;
    rd_model = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_access(1'b0, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0, 1'b0, "load_fast");
    run_access(1'b1, 32'h204, 32'h12345678, 3, 0, 32'h0, 1'b0, 1'b0, "store_gnt_wait");
    run_access(1'b0, 32'h300, 32'h0, 1, 2, 32'hCAFEF00D, 1'b1, 1'b0, "load_bus_err");
  endtask

  task automatic test_misaligned();
    pulse_reset();
    run_access(1'b0, 32'h102, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0, "load_misaligned");
    run_access(1'b1, 32'h207, 32'h55AA55AA, 0, 0, 32'h0, 1'b0, 1'b0, "store_misaligned");
  endtask

  task automatic test_reset_mid();
    run_access(1'b0, 32'h40, 32'h0, 0, 0, 32'h0BADF00D, 1'b0, 1'b0, "load_before_reset");
    MemAccess = 1'b1; MemWrite = 1'b0; ALUResult = 32'h300; WriteData = 32'h0;
    @(negedge clk);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    n_cmp++;
    if (bus_req !== 1'b0 || Stall !== 1'b1) begin
      n_bad++; $display("FAIL reset_mid in RESP: bus_req=%b Stall=%b want 0/1", bus_req, Stall);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (bus_req !== 1'b0 || Stall !== 1'b0 || BusErr !== 1'b0 || ReadData !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_mid outputs: bus_req=%b Stall=%b BusErr=%b ReadData=%h want 0/0/0/0",
               bus_req, Stall, BusErr, ReadData);
    end
    rd_model = 32'h0;
    @(negedge clk);
    reset = 1'b1;
    MemAccess = 1'b0;
    @(negedge clk);
    run_access(1'b0, 32'h308, 32'h0, 0, 1, 32'h13572468, 1'b0, 1'b0, "load_after_reset");
  endtask

  task automatic test_timeout();
`ifdef DMEM_BRIDGE_TIMEOUT_EN
    run_access(1'b0, 32'h400, 32'h0, 100000, 0, 32'h0, 1'b0, 1'b0, "load_timeout");
    run_access(1'b0, 32'h404, 32'h0, 0, 0, 32'h2468ACE0, 1'b0, 1'b0, "load_after_timeout");
`else
    bit held;
    held = 1;
    MemAccess = 1'b1; MemWrite = 1'b0; ALUResult = 32'h400; WriteData = 32'h0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      if (Stall !== 1'b1 || bus_req !== 1'b1) held = 0;
      @(negedge clk);
    end
    n_cmp++;
    if (held !== 1'b1) begin
      n_bad++; $display("FAIL no_timeout hold: Stall/bus_req dropped without grant, want held high");
    end
    pulse_reset();
`endif
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 30; i++) begin
      run_access(1'($urandom_range(0, 1)), {$urandom_range(0, 32'h3FFF), 2'b00}, $urandom,
                 $urandom_range(0, 2), $urandom_range(0, 2), $urandom,
                 ($urandom_range(0, 7) == 0), (i != 29) && ($urandom_range(0, 1) == 1), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_misaligned();
    test_reset_mid();
    test_timeout();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_dmem_bridge
